// File: rtl/jk_excitation_driver.sv
// Drives a bank of external JK flip-flops to a requested word and
// confirms the result by readback, re-driving a bounded number of times.
module jk_excitation_driver #(
    parameter int WIDTH   = 4,
    parameter int RETRIES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] tgt_data,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic             ff_reset_n,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int CW = $clog2(RETRIES + 2);
    localparam logic [CW-1:0] MAXR = CW'(RETRIES);

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_DRIVE,
        S_CHECK
    } state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nx;
    logic [WIDTH-1:0] r_tgt;
    logic [WIDTH-1:0] w_tgt_nx;
    logic [WIDTH-1:0] w_j_nx;
    logic [WIDTH-1:0] w_k_nx;
    logic             w_done_nx;
    logic             w_err_nx;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_INIT;
            r_cnt   <= '0;
            r_tgt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_tgt   <= w_tgt_nx;
        end
    end

    // Excitation only sets or clears bits that differ; toggle is never issued.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_tgt_nx   = r_tgt;
        w_j_nx     = '0;
        w_k_nx     = '0;
        w_done_nx  = 1'b0;
        w_err_nx   = 1'b0;
        unique case (r_state)
            S_INIT: begin
                w_state_nx = S_IDLE;
            end
            S_IDLE: begin
                if (tgt_valid && tgt_ready) begin
                    w_state_nx = S_DRIVE;
                    w_tgt_nx   = tgt_data;
                    w_cnt_nx   = '0;
                    w_j_nx     = ~q_fb & tgt_data;
                    w_k_nx     = q_fb & ~tgt_data;
                end
            end
            S_DRIVE: begin
                w_state_nx = S_CHECK;
            end
            S_CHECK: begin
                if (q_fb == r_tgt) begin
                    w_done_nx  = 1'b1;
                    w_state_nx = S_IDLE;
                end else if (r_cnt == MAXR) begin
                    w_err_nx   = 1'b1;
                    w_state_nx = S_IDLE;
                end else begin
                    w_cnt_nx   = r_cnt + CW'(1);
                    w_j_nx     = ~q_fb & r_tgt;
                    w_k_nx     = q_fb & ~r_tgt;
                    w_state_nx = S_DRIVE;
                end
            end
            default: begin
                w_state_nx = S_INIT;
            end
        endcase
    end

    // Outputs are registered from the next-state decode.
    always_ff @(posedge clk) begin
        if (!reset) begin
            j_out      <= '0;
            k_out      <= '0;
            tgt_ready  <= 1'b0;
            busy       <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            ff_reset_n <= 1'b0;
        end else begin
            j_out      <= w_j_nx;
            k_out      <= w_k_nx;
            tgt_ready  <= (w_state_nx == S_IDLE);
            busy       <= (w_state_nx != S_IDLE);
            done       <= w_done_nx;
            err        <= w_err_nx;
            ff_reset_n <= (w_state_nx != S_INIT);
        end
    end

endmodule

// File: doc/jk_excitation_driver.md
JK_EXCITATION_DRIVER -- requirements
Module: jk_excitation_driver

Interface
REQ-001 Parameter WIDTH, default 4: number of external jk_flipflop bits driven.
REQ-002 Parameter RETRIES, default 2: re-drive attempts after a failed readback before error.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-low.
REQ-005 tgt_valid  input  1  target word offered.
REQ-006 tgt_ready  output  1  block can accept a target word.
REQ-007 tgt_data  input  WIDTH  desired flip-flop bank state.
REQ-008 q_fb  input  WIDTH  current outputs of the external flip-flop bank, which shares clk.
REQ-009 j_out  output  WIDTH  J inputs to the bank.
REQ-010 k_out  output  WIDTH  K inputs to the bank.
REQ-011 ff_reset_n  output  1  active-low reset to the bank.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 done  output  1  one-cycle pulse: readback matched target.
REQ-014 err  output  1  one-cycle pulse: retries exhausted, readback still wrong.

Function
REQ-015 The FSM SHALL have states INIT, IDLE, DRIVE and CHECK; all outputs SHALL be registered.
REQ-016 INIT SHALL last exactly one cycle with ff_reset_n=0, then go to IDLE; ff_reset_n SHALL be 1 in all other states.
REQ-017 In IDLE, tgt_ready SHALL be 1; it SHALL be 0 in every other state.
REQ-018 When tgt_valid and tgt_ready are both 1 on an edge, the block SHALL latch tgt_data, clear the retry count and enter DRIVE.
REQ-019 On that same edge, j_out/k_out SHALL be loaded per bit from q_fb (current) and the target: 0->0 gives j=0,k=0; 0->1 gives j=1,k=0; 1->0 gives j=0,k=1; 1->1 gives j=0,k=0.
REQ-020 Don't-care excitations SHALL resolve to 0; toggle (j=k=1) SHALL never be issued.
REQ-021 DRIVE SHALL last exactly one cycle with the computed j/k presented, then enter CHECK with j_out=k_out=0.
REQ-022 In CHECK, the bank has captured the excitation; on the CHECK-exit edge the block SHALL compare q_fb to the latched target.
REQ-023 On match: done=1 for the following cycle and go to IDLE.
REQ-024 On mismatch with retry count < RETRIES: increment count, recompute j/k from the current q_fb, and re-enter DRIVE.
REQ-025 On mismatch with retry count = RETRIES: err=1 for the following cycle and go to IDLE.
REQ-026 Latency: from the accept edge to the done/err pulse SHALL be 2 cycles plus 2 per retry; with RETRIES=2 the worst case is 6 cycles.
REQ-027 done and err SHALL never both be 1; neither SHALL repeat without a new accept.
REQ-028 A target equal to q_fb SHALL still traverse DRIVE (j=k=0) and CHECK, then pulse done.
REQ-029 tgt_valid while busy SHALL be ignored; tgt_data SHALL not be sampled.
REQ-030 The accept edge coinciding with the done/err cycle SHALL be legal, since IDLE is re-entered with tgt_ready=1 in that cycle.

Reset
REQ-031 reset=0 on an edge SHALL force state INIT, j_out=0, k_out=0, tgt_ready=0, busy=1, done=0, err=0, ff_reset_n=0, and clear the retry count and latched target.
REQ-032 Reset during DRIVE or CHECK SHALL abort the operation without a done or err pulse; INIT SHALL follow the release of reset.

Verification
REQ-033 Release reset, bank at 0000, target 1010 -> j_out=1010, k_out=0000 for one cycle; done pulse 2 cycles after accept; q_fb=1010.
REQ-034 From 1010, target 0110 -> j_out=0100, k_out=1000 in DRIVE; done; q_fb=0110.
REQ-035 Target equal to q_fb (0110) -> j_out=k_out=0000; done after 2 cycles.
REQ-036 Bank model forces bit0 stuck at 0, target 0001 -> three DRIVE cycles (j_out=0001 each); err pulse 6 cycles after accept; no done.
REQ-037 reset=0 asserted during CHECK -> no done or err; next cycle INIT with ff_reset_n=0; then IDLE with tgt_ready=1.
REQ-038 tgt_valid held high during busy with changing tgt_data -> only the word present at the accept edge is used; the next accept occurs in the done cycle.
